// File: rtl/channel_reset_issuer_pkg.sv
// rtl/channel_reset_issuer_pkg.sv - shared reset/control constants and FSM encoding
// Contents:
//   N_CHAN_DEF          channel FPGA count, also used by the channel-side reset logic
//   *_CYCLES_DEF        default pulse, holdoff and poll-timeout lengths in clk50 cycles
//   state_t             issuer FSM state encoding
//   max3()              helper used to size the shared down-counter
package channel_reset_issuer_pkg;

    localparam int N_CHAN_DEF         = 5;
    localparam int PULSE_CYCLES_DEF   = 16;
    localparam int HOLDOFF_CYCLES_DEF = 300;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ASSERT     = 3'd1,
        ST_HOLDOFF    = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/channel_reset_issuer_sync_2ff.sv
// rtl/channel_reset_issuer_sync_2ff.sv - two-stage synchronizer for asynchronous level inputs
// Ports:
//   clk    destination clock
//   reset  synchronous active-high reset, clears both stages
//   d      asynchronous input bus (bits treated independently)
//   q      synchronized output, two clk cycles of latency
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= '0;
            stable <= '0;
        end else begin
            meta   <= d;
            stable <= meta;
        end
    end

    assign q = stable;

endmodule

// File: rtl/channel_reset_issuer.sv
// rtl/channel_reset_issuer.sv - issues a timed reset pulse to selected channel FPGAs and polls their ready lines
// Ports:
//   clk50           50 MHz clock, the only clock
//   reset_clk50     synchronous active-high reset
//   start           single-cycle request, honoured only in IDLE
//   chan_mask       channels to reset, latched when start is accepted
//   chan_ready      asynchronous per-channel ready lines
//   rst_to_channel  registered active-high reset lines to the channels
//   busy            high from the accepting edge through the DONE cycle
//   done            single-cycle completion pulse
//   ready_status    masked synchronized ready captured on completion
//   timeout         set on completion if the ready poll expired
module channel_reset_issuer
    import channel_reset_issuer_pkg::*;
#(
    parameter int N_CHAN         = N_CHAN_DEF,
    parameter int PULSE_CYCLES   = PULSE_CYCLES_DEF,
    parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk50,
    input  logic              reset_clk50,
    input  logic              start,
    input  logic [N_CHAN-1:0] chan_mask,
    input  logic [N_CHAN-1:0] chan_ready,
    output logic [N_CHAN-1:0] rst_to_channel,
    output logic              busy,
    output logic              done,
    output logic [N_CHAN-1:0] ready_status,
    output logic              timeout
);

    localparam int CNT_W = $clog2(max3(PULSE_CYCLES, HOLDOFF_CYCLES, TIMEOUT_CYCLES) + 1);

    // ASSERT and HOLDOFF count down to zero inclusive, so they load length-1.
    // WAIT_READY loads the full timeout: the zero-count cycle is one extra
    // poll, giving TIMEOUT_CYCLES+1 evaluations before giving up.
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [N_CHAN-1:0]   mask;
    logic [N_CHAN-1:0]   ready_sync;
    logic                all_ready;

    sync_2ff #(
        .WIDTH (N_CHAN)
    ) u_ready_sync (
        .clk   (clk50),
        .reset (reset_clk50),
        .d     (chan_ready),
        .q     (ready_sync)
    );

    assign all_ready = ((ready_sync & mask) == mask);

    always_ff @(posedge clk50) begin
        if (reset_clk50) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            mask           <= '0;
            rst_to_channel <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ready_status   <= '0;
            timeout        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        ready_status <= '0;
                        timeout      <= 1'b0;
                        if (chan_mask != '0) begin
                            mask           <= chan_mask;
                            rst_to_channel <= chan_mask;
                            cnt            <= PULSE_LOAD;
                            state          <= ST_ASSERT;
                        end else begin
                            // Empty mask: nothing to reset, report completion at once.
                            mask  <= '0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_ASSERT: begin
                    if (cnt == '0) begin
                        rst_to_channel <= '0;
                        cnt            <= HOLDOFF_LOAD;
                        state          <= ST_HOLDOFF;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == '0) begin
                        cnt   <= TIMEOUT_LOAD;
                        state <= ST_WAIT_READY;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WAIT_READY: begin
                    if (all_ready || (cnt == '0)) begin
                        ready_status <= ready_sync & mask;
                        timeout      <= ~all_ready;
                        done         <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_channel_reset_issuer.sv
// tb/tb_channel_reset_issuer.sv - scoreboard bench for channel_reset_issuer
module tb_channel_reset_issuer;

    localparam int N = 5;

    logic         clk50       = 1'b0;
    logic         reset_clk50 = 1'b1;
    logic         start       = 1'b0;
    logic [N-1:0] chan_mask   = '0;
    logic [N-1:0] chan_ready  = '0;
    logic [N-1:0] rst_to_channel;
    logic         busy;
    logic         done;
    logic [N-1:0] ready_status;
    logic         timeout;

    always #10 clk50 = ~clk50;

    channel_reset_issuer dut (
        .clk50          (clk50),
        .reset_clk50    (reset_clk50),
        .start          (start),
        .chan_mask      (chan_mask),
        .chan_ready     (chan_ready),
        .rst_to_channel (rst_to_channel),
        .busy           (busy),
        .done           (done),
        .ready_status   (ready_status),
        .timeout        (timeout)
    );

    typedef struct {
        int           done_at;
        logic [N-1:0] status;
        logic         tmo;
        int           pulses;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp     = 0;
    int           n_bad     = 0;
    int           cyc       = 0;
    int           e0        = 0;
    int           pulse_cnt = 0;
    logic [N-1:0] cur_mask  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 ns later. cyc is the index of the edge just passed.
    task automatic step();
        exp_t e;
        @(posedge clk50);
        #1;
        cyc++;
        if (rst_to_channel !== '0) begin
            pulse_cnt++;
            check("pulse_bits", rst_to_channel, cur_mask);
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc - e0, e.done_at);
                check("ready_status", ready_status, e.status);
                check("timeout", timeout, e.tmo);
                check("pulse_len", pulse_cnt, e.pulses);
                check("busy_in_done", busy, 1);
            end
        end
    endtask

    task automatic issue(input logic [N-1:0] m, input bit expect_done, input int done_at,
                         input logic [N-1:0] st, input logic tmo, input int pulses);
        exp_t e;
        e.done_at = done_at;
        e.status  = st;
        e.tmo     = tmo;
        e.pulses  = pulses;
        if (expect_done) sb.push_back(e);
        start     = 1'b1;
        chan_mask = m;
        cur_mask  = m;
        pulse_cnt = 0;
        e0        = cyc + 1;
        step();
        check("busy_after_accept", busy, 1);
        start     = 1'b0;
        // Scramble the mask after acceptance; it must have no effect.
        chan_mask = N'($urandom_range(0, 31));
    endtask

    task automatic run(input int budget, input int poke_a, input int poke_b, input bit poke_done,
                       input int ready_at, input logic [N-1:0] ready_val);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            start = ((cyc + 1 - e0) == poke_a) || ((cyc + 1 - e0) == poke_b);
            if (ready_at >= 0 && (cyc + 1 - e0) == ready_at) chan_ready = ready_val;
            step();
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            check("budget_expired", sb.size(), 0);
            sb.delete();
        end
        if (poke_done) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
    endtask

    task automatic idle_check(input int n, input logic [N-1:0] held_status, input logic held_tmo);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_busy", busy, 0);
            check("idle_rst", rst_to_channel, 0);
        end
        check("held_status", ready_status, held_status);
        check("held_timeout", timeout, held_tmo);
    endtask

    initial begin
        chan_ready = 5'b11111;
        for (int i = 0; i < 3; i++) step();
        check("reset_rst", rst_to_channel, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_status", ready_status, 0);
        check("reset_timeout", timeout, 0);
        reset_clk50 = 1'b0;
        step();

        // Ready already high: pulse E1..E16, done at E318.
        issue(5'b00101, 1, 317, 5'b00101, 1'b0, 16);
        run(400, -1, -1, 0, -1, '0);
        idle_check(3, 5'b00101, 1'b0);

        // Channel 3 never ready: timeout, done at E4414.
        chan_ready = 5'b10111;
        issue(5'b11111, 1, 4413, 5'b10111, 1'b1, 16);
        run(5000, -1, -1, 0, -1, '0);
        idle_check(3, 5'b10111, 1'b1);

        // Ready rises at the input 10 cycles after WAIT_READY entry.
        chan_ready = 5'b00000;
        issue(5'b00011, 1, 329, 5'b00011, 1'b0, 16);
        run(500, -1, -1, 0, 327, 5'b00011);
        idle_check(3, 5'b00011, 1'b0);

        // Start re-pulsed in ASSERT, HOLDOFF and DONE: all ignored.
        chan_ready = 5'b11111;
        issue(5'b01010, 1, 317, 5'b01010, 1'b0, 16);
        run(400, 5, 100, 1, -1, '0);
        idle_check(20, 5'b01010, 1'b0);

        // Empty mask: immediate done, no pulse, status cleared.
        issue(5'b00000, 1, 0, 5'b00000, 1'b0, 0);
        run(10, -1, -1, 0, -1, '0);
        idle_check(5, 5'b00000, 1'b0);

        // Reset at E8 of ASSERT aborts with no done.
        issue(5'b11001, 0, 0, 5'b00000, 1'b0, 0);
        for (int i = 0; i < 7; i++) step();
        reset_clk50 = 1'b1;
        step();
        check("abort_rst", rst_to_channel, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pulses", pulse_cnt, 8);
        reset_clk50 = 1'b0;
        idle_check(30, 5'b00000, 1'b0);

        // Full transaction after abort.
        issue(5'b11001, 1, 317, 5'b11001, 1'b0, 16);
        run(400, -1, -1, 0, -1, '0);
        idle_check(3, 5'b11001, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
